// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants, clear-FSM state encoding and width helpers
// for the parametrised simple-dual-port SRAM.
package dpram_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} clr_state_e;
    function automatic int num_bytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction
    function automatic bit widths_ok(input int data_w, input int byte_w);
        return (byte_w > 0) && (data_w % byte_w == 0);
    endfunction
endpackage

// File: rtl/dpram_clear_fsm.sv
// dpram_clear_fsm: clear engine that sweeps INIT_VALUE through the array and
// otherwise passes the user write port through to the array.
module dpram_clear_fsm import dpram_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BYTES = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    input  logic                  wen,
    input  logic [NUM_BYTES-1:0]  wbe,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic                  init_busy,
    output logic                  mem_we,
    output logic [NUM_BYTES-1:0]  mem_wbe,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);
    clr_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end

    // The last address is written on the same edge that moves us to READY.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        if (clear_req) begin
            state_d = ST_CLEAR;
            cnt_d = '0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == '1) state_d = ST_READY;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        init_busy = state_q == ST_CLEAR;
        mem_we = init_busy | wen;
        mem_wbe = init_busy ? '1 : wbe;
        mem_waddr = init_busy ? cnt_q : waddr;
        mem_wdata = init_busy ? INIT_VALUE : d_in;
    end
endmodule

// File: rtl/dual_port_sram_param.sv
// dual_port_sram_param: single-clock simple-dual-port RAM with byte enables,
// selectable read-during-write, optional output register and clear engine.
module dual_port_sram_param import dpram_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8,
    parameter int OUT_REG = 0,
    parameter int RDW_MODE = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  init_busy,
    input  logic                  wen,
    input  logic [NUM_BYTES-1:0]  wbe,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  rvalid
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!widths_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [NUM_BYTES-1:0]  mem_wbe;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en, fwd;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d, d_out_q, d_out_d;
    logic                  p_valid_q, p_valid_d, rvalid_q, rvalid_d;

    dpram_clear_fsm #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_BYTES(NUM_BYTES),
        .INIT_VALUE(INIT_VALUE)
    ) u_clear (
        .clk(clk),
        .rst_n(rst_n),
        .clear_req(clear_req),
        .wen(wen),
        .wbe(wbe),
        .waddr(waddr),
        .d_in(d_in),
        .init_busy(init_busy),
        .mem_we(mem_we),
        .mem_wbe(mem_wbe),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < NUM_BYTES; i++)
                if (mem_wbe[i])
                    mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // Write-through merges only the enabled lanes over the stored word.
    always_comb begin
        rd_en = ren & ~init_busy;
        fwd = (RDW_MODE == RDW_NEW) && wen && !init_busy && (waddr == raddr);
        rd_word = mem[raddr];
        for (int i = 0; i < NUM_BYTES; i++)
            if (fwd && wbe[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = d_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        p_valid_d = rd_en;
        p_data_d = rd_en ? rd_word : p_data_q;
        rvalid_d = (OUT_REG != 0) ? p_valid_q : rd_en;
        d_out_d = !rvalid_d ? d_out_q : (OUT_REG != 0) ? p_data_q : rd_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= 1'b0;
            p_data_q <= '0;
            rvalid_q <= 1'b0;
            d_out_q <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_data_q <= p_data_d;
            rvalid_q <= rvalid_d;
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;
    assign rvalid = rvalid_q;
endmodule

// File: tb/tb_dual_port_sram_param.sv
// tb_dual_port_sram_param: scoreboard bench driving two RAM variants
// (1-cycle/old-data and 2-cycle/write-through) from one stimulus stream.
module tb_dual_port_sram_param;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;
    localparam int DEPTH = 16;

    typedef struct { int cyc; logic [31:0] d; } exp_t;

    logic        clk = 1'b0, rst_n = 1'b1, clear_req = 1'b0, wen = 1'b0, ren = 1'b0;
    logic [3:0]  wbe = '0, waddr = '0, raddr = '0;
    logic [31:0] d_in = '0;
    logic        busy [2];
    logic        rv [2];
    logic [31:0] dout [2];
    logic [31:0] hold [2];
    logic [31:0] mem_m [DEPTH];
    exp_t        q [2][$];
    exp_t        e_mon;
    int          cyc = 0, checks = 0, errors = 0;

    dual_port_sram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(0),
                           .RDW_MODE(0), .INIT_VALUE(INIT)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy[0]),
        .wen(wen), .wbe(wbe), .waddr(waddr), .d_in(d_in),
        .ren(ren), .raddr(raddr), .d_out(dout[0]), .rvalid(rv[0]));

    dual_port_sram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(1),
                           .RDW_MODE(1), .INIT_VALUE(INIT)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy[1]),
        .wen(wen), .wbe(wbe), .waddr(waddr), .d_in(d_in),
        .ren(ren), .raddr(raddr), .d_out(dout[1]), .rvalid(rv[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (q[k].size() > 0 && q[k][0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_rvalid dut%0d: got no strobe, required at cycle %0d", k, q[k][0].cyc);
                    void'(q[k].pop_front());
                end
                if (rv[k]) begin
                    if (q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 required 0 at cycle %0d", k, cyc);
                    end else begin
                        e_mon = q[k].pop_front();
                        chk($sformatf("rvalid_cycle_dut%0d", k), 32'(cyc), 32'(e_mon.cyc));
                        chk($sformatf("rdata_dut%0d", k), dout[k], e_mon.d);
                        hold[k] = e_mon.d;
                    end
                end else begin
                    chk($sformatf("dout_hold_dut%0d", k), dout[k], hold[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) mem_m[a] = INIT;
    endtask

    // Reference: reads see the array as it was before this cycle's write,
    // except that the write-through variant sees the merged word.
    task automatic op(input logic w, input logic [3:0] be, input logic [3:0] wa,
                      input logic [31:0] din, input logic r, input logic [3:0] ra);
        logic [31:0] old, merged;
        wen = w; wbe = be; waddr = wa; d_in = din; ren = r; raddr = ra;
        old = mem_m[ra];
        merged = mem_m[wa];
        for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = din[b*8 +: 8];
        if (r) begin
            q[0].push_back('{cyc + 1, old});
            q[1].push_back('{cyc + 2, (w && wa == ra) ? merged : old});
        end
        if (w) mem_m[wa] = merged;
        step();
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic check_busy(input bit noisy);
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) chk($sformatf("init_busy_high_dut%0d", k), 32'(busy[k]), 32'd1);
            if (noisy) begin
                wen = 1'b1; wbe = 4'hF; waddr = 4'($urandom); d_in = $urandom;
                ren = 1'b1; raddr = 4'($urandom);
            end
            step();
        end
        wen = 1'b0;
        ren = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("init_busy_low_dut%0d", k), 32'(busy[k]), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            hold[k] = '0;
            chk($sformatf("reset_dout_dut%0d", k), dout[k], 32'd0);
            chk($sformatf("reset_rvalid_dut%0d", k), 32'(rv[k]), 32'd0);
        end
        step();
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    endtask

    initial begin
        #2;
        do_reset();
        check_busy(1'b0);
        read_all();
        op(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'd0);
        op(1'b1, 4'b0101, 4'd3, 32'hFFFFFFFF, 1'b0, 4'd0);
        op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
        op(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'd0);
        op(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5);
        op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
        for (int i = 0; i < 4; i++) op(1'b1, 4'hF, 4'(i), 32'(10 + i), 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
        repeat (4) step();
        repeat (400)
            op(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
        op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd9);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        model_clear();
        check_busy(1'b1);
        read_all();
        for (int i = 0; i < 4; i++) op(1'b1, 4'hF, 4'(i), $urandom, 1'b0, 4'd0);
        do_reset();
        repeat (7) step();
        do_reset();
        check_busy(1'b0);
        op(1'b1, 4'hF, 4'd1, 32'h12345678, 1'b0, 4'd0);
        op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
        do_reset();
        check_busy(1'b0);
        read_all();
        repeat (4) step();
        for (int k = 0; k < 2; k++) chk($sformatf("queue_drained_dut%0d", k), 32'(q[k].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_port_sram_param.md
Name: dual_port_sram_param

Overview:
Parametrised simple-dual-port SRAM: one write port, one read port, single clock.
Generalises the fixed 32x1024 RAM in width and depth, and adds per-byte write enables, selectable read-during-write semantics, an optional output pipeline register, a read-valid strobe and a hardware clear engine.
Sits under the FPGA memory-block wrappers as the common RAM primitive for all memory configurations.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH.
BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (write-through).
INIT_VALUE, 0, word written to every location by the clear engine.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clear_req  input  1  one-cycle pulse; restarts the clear engine.
init_busy  output  1  high while the clear engine runs; ports are ignored.
wen  input  1  write enable.
wbe  input  NUM_BYTES  byte-lane write mask; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
waddr  input  ADDR_WIDTH  write address.
d_in  input  DATA_WIDTH  write data.
ren  input  1  read enable.
raddr  input  ADDR_WIDTH  read address.
d_out  output  DATA_WIDTH  read data; holds its value until the next valid read.
rvalid  output  1  one-cycle strobe marking new d_out.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM -> CLEAR; clear counter = 0; init_busy = 1.
  - d_out = 0; rvalid = 0; read pipeline valid bits = 0.
  - Memory array is not reset asynchronously.
- FSM states are CLEAR and READY.
  - CLEAR: each cycle write INIT_VALUE to address counter, then increment the counter.
  - Leave CLEAR on the cycle the counter reaches depth-1: that write completes and the FSM moves to READY.
  - Clear takes exactly 2**ADDR_WIDTH cycles after reset release; init_busy is 0 from the following cycle.
- READY -> CLEAR on clear_req; counter reset to 0.
  - clear_req while already in CLEAR restarts the counter at 0.
- During CLEAR:
  - wen and ren are ignored; no rvalid.
  - d_out holds its value.
  - An in-flight OUT_REG=1 read still completes.
- Write (READY, wen=1): at the clock edge, mem[waddr] lanes with wbe[i]=1 take d_in lanes; other lanes are unchanged. wen=1 with wbe=0 is a no-op.
- Read (READY, ren=1):
  - OUT_REG=0: d_out = mem[raddr] and rvalid = 1 one cycle after the request edge.
  - OUT_REG=1: the same data and strobe appear two cycles after the request edge.
  - Back-to-back reads are accepted every cycle; no stalls.
  - ren=0: rvalid = 0 and d_out holds.
- Read-during-write, same cycle, raddr == waddr:
  - RDW_MODE=0: return the pre-write word.
  - RDW_MODE=1: return the merged word — enabled lanes from d_in, other lanes from the old word.
  - Different addresses: no interaction.
- Address wrap: the clear counter wraps to 0 only when restarted. Addresses are always in range, since depth is a power of two.
- Reset mid-operation: any pending read is discarded (no rvalid) and the clear restarts from 0.

Decomposition:
- Package dpram_pkg:
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - State encoding for CLEAR/READY.
  - Function computing NUM_BYTES.
  - Elaboration check that DATA_WIDTH % BYTE_WIDTH == 0.
- Sub-module dpram_clear_fsm: FSM, counter, init_busy, and the muxed write port (address, data, enable) into the array.
- Array, read path, RDW bypass and output register stay in the top module.

Test Plan:
1. Reset release with ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5 -> init_busy high for exactly 16 cycles; afterwards reading addresses 0..15 returns A5A5A5A5 each, with rvalid one cycle after each ren.
2. Write 32'h11223344 to address 3 with wbe=4'b1111, then 32'hFFFFFFFF with wbe=4'b0101 -> read of address 3 returns 32'h11FF33FF.
3. Same-cycle write 32'hDEADBEEF (wbe=1111) and read of address 5, which holds 32'h0 -> RDW_MODE=0 gives d_out=0; RDW_MODE=1 gives d_out=DEADBEEF. The next read returns DEADBEEF in both modes.
4. OUT_REG=1, ren on 4 consecutive cycles to addresses 0..3 holding 10,11,12,13 -> rvalid high on cycles +2..+5 with d_out 10,11,12,13 in order; d_out holds 13 afterwards.
5. clear_req after writes, with ren and wen asserted during the clear -> no rvalid and no array update during init_busy; all locations read INIT_VALUE afterwards.
6. rst_n asserted mid-clear at counter=7, and mid-read (OUT_REG=1) -> d_out=0 and rvalid=0 immediately; the read is dropped; init_busy lasts the full 16 cycles after release.
